mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 50 +++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory arbiter.
// Optional build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef logic owner_t;

    localparam owner_t OWNER_0 = 1'b0;
    localparam owner_t OWNER_1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection with a last-served pointer (round-robin by default).
// Build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties and the pointer is removed.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       gnt_valid_c,
    output owner_t     gnt_id_c
);

    assign gnt_valid_c = |req_i;

`ifdef MEM_ARB_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, advance_i};

    always_comb begin
        gnt_id_c = OWNER_0;
        if (req_i[1] && !req_i[0]) begin
            gnt_id_c = OWNER_1;
        end
    end

`else

    owner_t last_q;

    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWNER_1;
        end else if (advance_i) begin
            last_q <= gnt_id_c;
        end
    end

    always_comb begin
        gnt_id_c = OWNER_0;
        if (req_i[1] && (!req_i[0] || (last_q == OWNER_0))) begin
            gnt_id_c = OWNER_1;
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single synchronous memory port: IDLE -> ACCESS -> RESP.
// Build macro MEM_ARB_FIXED_PRIO_EN switches tie-breaking from round-robin to fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] DataIn,
    output logic              rdEn,
    output logic              wrEn,
    input  logic [DATA_W-1:0] DataOut
);

    state_e            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            gnt_id;
    logic              gnt_valid;
    logic              grant;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    assign grant = (state_q == IDLE) && gnt_valid;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (resetN),
        .req_i       ({req1, req0}),
        .advance_i   (grant),
        .gnt_valid_c (gnt_valid),
        .gnt_id_c    (gnt_id)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is captured once at grant; later input changes are ignored until the next IDLE.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_id;
                    we_d    = (gnt_id == OWNER_1) ? we1 : we0;
                    addr_d  = (gnt_id == OWNER_1) ? addr1 : addr0;
                    din_d   = (gnt_id == OWNER_1) ? wdata1 : wdata0;
                    rd_d    = ~we_d;
                    wr_d    = we_d;
                end
            end
            RESP: begin
                if (!we_q) begin
                    rdata_d = DataOut;
                end
                ack0_d = (owner_q == OWNER_0);
                ack1_d = (owner_q == OWNER_1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            owner_q <= OWNER_0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign Addr   = addr_q;
    assign DataIn = din_q;
    assign rdEn   = rd_q;
    assign wrEn   = wr_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata  = rdata_q;

endmodule
